scg_auto_ref_burst: RTL and testbench

SDRAM command-generator sub-block that issues a configurable burst of AUTO REFRESH commands, honouring tRFC between them. It is the parametrised successor to the single-refresh generator, adding a burst count, a parametrised recovery time and a busy flag. It sits under the SDRAM controller's command mux, which grants it the command bus while busy=1.

---
 rtl/scg_auto_ref_burst.sv | 110 +++++++++++
 tb/tb_scg_auto_ref_burst.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/scg_auto_ref_burst.sv
// AUTO REFRESH burst generator: issues burst_len REF commands spaced TRFC_CYC apart.
// Optional macro SCG_REF_PRECHARGE_EN prepends PRECHARGE_ALL plus a TRP_CYC recovery.
module scg_auto_ref_burst #(
  parameter int TRFC_CYC = 10,
  parameter int TRP_CYC  = 3,
  parameter int BURST_W  = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  output logic [3:0]         command,
  output logic               busy,
  output logic               done
);

  localparam int WAIT_W = $clog2(256);
  localparam logic [WAIT_W-1:0] TRFC_LOAD = WAIT_W'(TRFC_CYC - 2);

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_REF = 4'd5;
`ifdef SCG_REF_PRECHARGE_EN
  localparam logic [3:0] CMD_PRE = 4'd2;
  localparam logic [WAIT_W-1:0] TRP_LOAD = WAIT_W'((TRP_CYC > 1) ? TRP_CYC - 2 : 0);
`endif

  // Reject parameter values outside the legal ranges at elaboration time.
  if (TRFC_CYC < 2 || TRFC_CYC > 255 || TRP_CYC < 1 || TRP_CYC > 255 || BURST_W < 1) begin : g_bad_param
    $error("scg_auto_ref_burst: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
`ifdef SCG_REF_PRECHARGE_EN
    PRE,
    PRE_WAIT,
`endif
    REF,
    REF_WAIT,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [BURST_W-1:0] remaining;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [3:0]         command_next;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_next   = state;
    command_next = CMD_NOP;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef SCG_REF_PRECHARGE_EN
          state_next = PRE;
`else
          state_next = REF;
`endif
        end
      end
`ifdef SCG_REF_PRECHARGE_EN
      PRE:      state_next = (TRP_CYC > 1) ? PRE_WAIT : REF;
      PRE_WAIT: if (wait_cnt == '0) state_next = REF;
`endif
      REF:      state_next = REF_WAIT;
      REF_WAIT: if (wait_cnt == '0) state_next = (remaining != '0) ? REF : DONE;
      DONE:     if (!start) state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    if (state_next == REF) command_next = CMD_REF;
`ifdef SCG_REF_PRECHARGE_EN
    if (state_next == PRE) command_next = CMD_PRE;
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (!n_rst) begin
      state     <= IDLE;
      command   <= CMD_NOP;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      wait_cnt  <= '0;
    end else begin
      state   <= state_next;
      command <= command_next;
      busy    <= (state_next != IDLE);
      done    <= (state_next == DONE);

      if (state == IDLE && start)
        remaining <= (burst_len == '0) ? BURST_W'(1) : burst_len;
      else if (state == REF)
        remaining <= remaining - BURST_W'(1);

      if (state == REF)
        wait_cnt <= TRFC_LOAD;
`ifdef SCG_REF_PRECHARGE_EN
      else if (state == PRE)
        wait_cnt <= TRP_LOAD;
`endif
      else if (wait_cnt != '0)
        wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_scg_auto_ref_burst.sv
// Randomised bench for scg_auto_ref_burst against a cycle-index reference model.
// Honours SCG_REF_PRECHARGE_EN when compiled with it.
module tb_scg_auto_ref_burst;

  localparam int TRFC = 10;
  localparam int TRP  = 3;
  localparam int BW   = 4;
`ifdef SCG_REF_PRECHARGE_EN
  localparam int PRE_CYC = TRP;
`else
  localparam int PRE_CYC = 0;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [BW-1:0] burst_len;
  logic [3:0]    command;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scg_auto_ref_burst #(.TRFC_CYC(TRFC), .TRP_CYC(TRP), .BURST_W(BW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .burst_len (burst_len),
    .command   (command),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: cycle at which done first rises, counting the acceptance edge as 0.
  function automatic int done_cycle(input int n);
    return 1 + PRE_CYC + n * TRFC;
  endfunction

  // Reference: expected command during cycle c of an n-refresh sequence.
  function automatic int exp_cmd(input int c, input int n);
    if (PRE_CYC != 0 && c == 1) return 2;
    for (int i = 0; i < n; i++)
      if (c == 1 + PRE_CYC + i * TRFC) return 5;
    return 0;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".cmd"},  32'(command), 32'd0);
    check({tag, ".busy"}, 32'(busy),    32'd0);
    check({tag, ".done"}, 32'(done),    32'd0);
  endtask

  // Called at a negedge with the DUT idle. start drops for edges >= drop.
  task automatic run_burst(input string tag, input int len, input int drop, input bit scramble);
    int n, dc, e;
    n  = (len == 0) ? 1 : len;
    dc = done_cycle(n);
    e  = (drop > dc) ? drop : dc;
    start     = 1'b1;
    burst_len = BW'(len);
    for (int c = 1; c <= e + 2; c++) begin
      @(negedge clk);
      check({tag, ".cmd"},  32'(command), 32'(exp_cmd(c, n)));
      check({tag, ".busy"}, 32'(busy),    32'(c <= e));
      check({tag, ".done"}, 32'(done),    32'(c >= dc && c <= e));
      if (c >= drop) start = 1'b0;
      if (scramble) burst_len = BW'($urandom);
    end
  endtask

  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_idle("gap");
    end
  endtask

  initial begin
    n_rst     = 1'b0;
    start     = 1'b0;
    burst_len = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    n_rst = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Reset in the middle of the second REF_WAIT of a 3-refresh burst.
    start     = 1'b1;
    burst_len = BW'(3);
    for (int c = 1; c <= 14 + PRE_CYC; c++) begin
      @(negedge clk);
      check("mid.cmd",  32'(command), 32'(exp_cmd(c, 3)));
      check("mid.busy", 32'(busy),    32'd1);
    end
    n_rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    n_rst = 1'b1;
    idle_gap(4);

    // Directed sequences.
    run_burst("single_a", 1, done_cycle(1) + 3, 1'b0);
    run_burst("single_b", 1, done_cycle(1) + 3, 1'b0);
    idle_gap(1);
    run_burst("burst3", 3, done_cycle(3) + 2, 1'b1);
    idle_gap(1);
    run_burst("len0", 0, done_cycle(1) + 1, 1'b0);
    run_burst("early_drop", 2, 3, 1'b0);
    idle_gap(2);

    // Randomised sequences: random length, early or late start drop, random gaps.
    for (int k = 0; k < 16; k++) begin
      int len, n, drop;
      len = int'($urandom_range(0, 15));
      n   = (len == 0) ? 1 : len;
      if ($urandom_range(0, 1) == 0)
        drop = int'($urandom_range(1, done_cycle(n)));
      else
        drop = done_cycle(n) + int'($urandom_range(0, 3));
      run_burst("rand", len, drop, 1'b1);
      idle_gap(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
